// File: rtl/note_sequencer_pkg.sv
// Shared definitions for the note sequencer: step-word layout, FSM encoding
// and the minimum tempo used to keep a gap between consecutive notes.
package note_sequencer_pkg;

    localparam int WORD_W    = 17;
    localparam int REST_BIT  = 16;
    localparam int GATE_MSB  = 15;
    localparam int GATE_LSB  = 12;
    localparam int GATE_W    = GATE_MSB - GATE_LSB + 1;
    localparam int COUNT_W   = 12;
    localparam int TEMPO_MIN = 2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_GATE  = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    typedef struct packed {
        logic               rest;
        logic [GATE_W-1:0]  gate;
        logic [COUNT_W-1:0] count;
    } step_word_t;

    // Builds a step word from its fields.
    function automatic logic [WORD_W-1:0] packStep(
        input logic               rest,
        input logic [GATE_W-1:0]  gate,
        input logic [COUNT_W-1:0] count
    );
        return {rest, gate, count};
    endfunction

endpackage

// File: rtl/seq_step_ram.sv
// Pattern memory: one write port and one synchronous read-first read port.
module seq_step_ram
    import note_sequencer_pkg::*;
#(
    parameter int STEPS = 16,
    parameter int IW    = $clog2(STEPS)
) (
    input  logic              i_clk,
    input  logic              i_wrEn,
    input  logic [IW-1:0]     i_wrAddr,
    input  logic [WORD_W-1:0] i_wrData,
    input  logic [IW-1:0]     i_rdAddr,
    output logic [WORD_W-1:0] o_rdData
);

    logic [WORD_W-1:0] r_mem [STEPS];

    // A same-address write lands after the read samples the old word.
    always_ff @(posedge i_clk) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
        o_rdData <= r_mem[i_rdAddr];
    end

endmodule

// File: rtl/note_sequencer.sv
// Step sequencer that walks a programmable pattern and drives oscillator pitch
// and ADSR gate, paced by the envelope-rate tick strobe.
module note_sequencer
    import note_sequencer_pkg::*;
#(
    parameter  int STEPS   = 16,
    parameter  int TEMPO_W = 8,
    localparam int IW      = $clog2(STEPS)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_tick,
    input  logic               i_run,
    input  logic [TEMPO_W-1:0] i_tempo,
    input  logic [IW-1:0]      i_lastStep,
    input  logic               i_wrEn,
    input  logic [IW-1:0]      i_wrAddr,
    input  logic [WORD_W-1:0]  i_wrData,
    output logic [COUNT_W-1:0] o_oscCount,
    output logic               o_trig,
    output logic [IW-1:0]      o_stepIdx,
    output logic               o_stepStb,
    output logic               o_busy
);

    logic [1:0]         r_state;
    logic [TEMPO_W-1:0] r_stepCnt;
    logic [GATE_W-1:0]  r_gateCnt;

    logic [WORD_W-1:0]  w_rdData;
    step_word_t         w_word;
    logic [IW-1:0]      w_nextIdx;
    logic [IW-1:0]      w_rdAddr;
    logic [TEMPO_W-1:0] w_tempoEff;
    logic [TEMPO_W-1:0] w_gateLimit;
    logic [TEMPO_W-1:0] w_gateWide;
    logic [TEMPO_W-1:0] w_gateEff;

    assign w_word = w_rdData;

    // An index at or past last_step wraps, so lowering last_step mid-pattern is safe.
    assign w_nextIdx = (o_stepIdx >= i_lastStep) ? '0 : o_stepIdx + IW'(1);

    // In GAP the read is aimed at the next step so its word is ready during FETCH.
    assign w_rdAddr = (r_state == S_GAP) ? w_nextIdx : o_stepIdx;

    assign w_tempoEff  = (i_tempo < TEMPO_W'(TEMPO_MIN)) ? TEMPO_W'(TEMPO_MIN) : i_tempo;
    assign w_gateLimit = w_tempoEff - TEMPO_W'(1);
    assign w_gateWide  = TEMPO_W'(w_word.gate);
    assign w_gateEff   = (w_gateWide < w_gateLimit) ? w_gateWide : w_gateLimit;

    seq_step_ram #(
        .STEPS (STEPS),
        .IW    (IW)
    ) u_ram (
        .i_clk    (i_clk),
        .i_wrEn   (i_wrEn),
        .i_wrAddr (i_wrAddr),
        .i_wrData (i_wrData),
        .i_rdAddr (w_rdAddr),
        .o_rdData (w_rdData)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_stepCnt  <= '0;
            r_gateCnt  <= '0;
            o_oscCount <= '0;
            o_trig     <= 1'b0;
            o_stepIdx  <= '0;
            o_stepStb  <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            o_stepStb <= 1'b0;
            // Stopping keeps the pitch so the release tail stays in tune.
            if (!i_run) begin
                r_state   <= S_IDLE;
                o_trig    <= 1'b0;
                o_stepIdx <= '0;
                o_busy    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_tick) begin
                            r_state <= S_FETCH;
                            o_busy  <= 1'b1;
                        end
                    end
                    S_FETCH: begin
                        o_stepStb <= 1'b1;
                        r_stepCnt <= w_tempoEff;
                        r_gateCnt <= GATE_W'(w_gateEff);
                        if (!w_word.rest) begin
                            o_oscCount <= w_word.count;
                        end
                        if (w_word.rest || (w_gateEff == '0)) begin
                            r_state <= S_GAP;
                            o_trig  <= 1'b0;
                        end else begin
                            r_state <= S_GATE;
                            o_trig  <= 1'b1;
                        end
                    end
                    S_GATE: begin
                        if (i_tick) begin
                            r_stepCnt <= r_stepCnt - TEMPO_W'(1);
                            r_gateCnt <= r_gateCnt - GATE_W'(1);
                            if (r_gateCnt == GATE_W'(1)) begin
                                o_trig  <= 1'b0;
                                r_state <= S_GAP;
                            end
                        end
                    end
                    S_GAP: begin
                        if (i_tick) begin
                            r_stepCnt <= r_stepCnt - TEMPO_W'(1);
                            if (r_stepCnt == TEMPO_W'(1)) begin
                                o_stepIdx <= w_nextIdx;
                                r_state   <= S_FETCH;
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        o_trig  <= 1'b0;
                        o_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
